rb2_serial_writer: RTL and testbench
====================================

// Module: rb2_serial_writer
// PURPOSE
//  Downstream receiver stage for the serial link driven by the RB1 serializer.
//  Deserializes each sen/sd frame (3-bit address, then 18-bit data word) and writes the word into register bank RB2.
//  Asserts done once NUM_FRAMES frames are written. RB2 is the final result store.
// PARAMETERS
//  ADDR_W      3   frame address bits; also RB2 address width
//  DATA_W      18  frame data bits; also RB2 word width
//  NUM_FRAMES  8   number of frame writes after which done asserts
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  sen        in   1       serial enable, active low; high = link idle
//  sd         in   1       serial data; valid every cycle sen==0
//  RB2_RW     out  1       RB2 control: 1 = read/idle, 0 = write
//  RB2_A      out  ADDR_W  RB2 address
//  RB2_D      out  DATA_W  RB2 write data
//  RB2_Q      in   DATA_W  RB2 read data; unused, kept for bank interface
//  done       out  1       all NUM_FRAMES frames written; sticky
//  frame_err  out  1       only with FRAME_CHECK_EN; 1-cycle error pulse
// BEHAVIOUR
//  Reset (rst==1 at posedge) overrides everything and applies mid-frame.
//   RB2_RW=1, RB2_A=0, RB2_D=0, done=0, frame_err=0.
//   Shift reg, bit cnt and frame cnt clear to 0; state <= IDLE.
//  Frame format: bits taken MSB first, one per cycle while sen==0.
//   Bits 0..2 = addr[2:0]; bits 3..20 = data[17:0].
//   21 bits total = ADDR_W+DATA_W.
//  FSM states: IDLE, RECV, WRITE, WAIT_HI, DONE.
//   IDLE: sen==0 -> capture first sd bit, bitcnt=1, go RECV.
//   RECV: sen==0 -> shift in sd, bitcnt++.
//    Once the 21st bit is captured, go WRITE.
//    sen==1 before 21 bits -> short frame, discarded; go IDLE.
//   WRITE (exactly 1 cycle): RB2_RW=0, RB2_A=addr, RB2_D=data.
//    frame cnt++. If frame cnt reaches NUM_FRAMES, go DONE.
//    Otherwise go WAIT_HI if sen==0, else IDLE.
//   WAIT_HI: sen==0 -> ignore sd (overlong frame tail); sen==1 -> IDLE.
//   DONE: done=1; RB2_RW=1; sen/sd ignored until rst.
//  RB2 outputs are registered.
//   Write strobe is at cycle N+1, where N is the cycle of the 21st bit.
//   RB2_RW returns to 1 the following cycle.
//   RB2_A/RB2_D hold their last written values.
//  Frame boundary: a new frame needs sen==1 for at least one cycle, then sen==0.
//   sen held low across 21+ bits never starts a second frame.
//  Duplicate addresses overwrite; each still counts toward NUM_FRAMES.
//  Frame counter width is clog2(NUM_FRAMES)+1; it does not wrap; saturates in DONE.
// CONFIGURATION
//  FRAME_CHECK_EN defined:
//   Short frame (RECV exit with <21 bits) -> frame_err=1 for one cycle, in IDLE-entry cycle.
//   Overlong frame (WAIT_HI entered) -> frame_err=1 for one cycle, in WAIT_HI-entry cycle.
//   The overlong frame's write still occurs.
//  FRAME_CHECK_EN undefined: frame_err port absent.
//   Short frames are dropped silently; overlong tails are ignored silently.
// STRUCTURE
//  Shared package: state encoding localparams.
//   Also FRAME_BITS = ADDR_W+DATA_W and RB_WRITE=0 / RB_READ=1 constants.
//   Must match the RB1 serializer's encoding.
//  Sub-module serial_shift_in: FRAME_BITS-wide shift reg plus bit counter.
//   Outputs the full flag and the parallel word.
//   FSM, RB2 drive and frame counter stay in the top module.
// TESTING
//  Frame addr=3'b101, data=18'h2A5C3 -> one cycle after 21st bit:
//   RB2_RW=0, RB2_A=5, RB2_D=18'h2A5C3.
//  8 frames to addr 0..7, data=addr*18'h01111, sen high 19 cycles between frames:
//   8 write strobes; done=1 the cycle after 8th write; later frames give no writes.
//  sen low only 10 cycles, then high, then valid frame addr=2, data=18'h3FFFF:
//   single write to addr 2; frame_err pulse (FRAME_CHECK_EN).
//  sen held low 25 cycles, first 21 bits addr=1, data=18'h00001:
//   one write; 4 tail bits ignored; frame_err pulse (FRAME_CHECK_EN).
//  rst asserted at bit 12 of a frame, then a full frame addr=7, data=18'h12345:
//   no write from the first frame; write 7/18'h12345; frame cnt=1.

Source files
------------

// File: rtl/rb2_serial_writer_pkg.sv
// Shared encodings for the RB1->RB2 serial link: FSM states, frame size, RB control levels.
// These must stay in step with the RB1 serializer's package.
package rb2_serial_writer_pkg;

  localparam int unsigned RB_ADDR_W  = 3;
  localparam int unsigned RB_DATA_W  = 18;
  localparam int unsigned FRAME_BITS = RB_ADDR_W + RB_DATA_W;

  localparam logic RB_WRITE = 1'b0;
  localparam logic RB_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    WRITE   = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/rb2_serial_writer_shift_in.sv
// serial_shift_in: MSB-first frame shift register with bit counter.
// full/word are look-ahead: they describe the frame as it stands once the current sd bit is taken.
module serial_shift_in #(
  parameter int unsigned WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             sd,
  output logic             full,
  output logic [WIDTH-1:0] word
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-2:0] sh;
  logic [CW-1:0]    cnt;

  assign word = {sh, sd};
  assign full = shift && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sh  <= word[WIDTH-2:0];
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rb2_serial_writer.sv
// RB2 receiver: deserializes sen/sd frames (addr then data, MSB first) and writes them into RB2.
// Optional framing-error pulse output enabled by defining FRAME_CHECK_EN.
module rb2_serial_writer
  import rb2_serial_writer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned NUM_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q,
`ifdef FRAME_CHECK_EN
  output logic              frame_err,
`endif
  output logic              done
);

  localparam int unsigned FW    = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(NUM_FRAMES) + 1;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic             shift;
  logic             full;
  logic [FW-1:0]    word;
  logic             unused_q;

  assign unused_q = ^RB2_Q;
  assign shift    = ((state == IDLE) || (state == RECV)) && !sen;

  serial_shift_in #(.WIDTH(FW)) u_shift_in (
    .clk   (clk),
    .rst   (rst),
    .clr   (!shift),
    .shift (shift),
    .sd    (sd),
    .full  (full),
    .word  (word)
  );

  // RB2 drive is loaded on the 21st-bit edge so the strobe coincides with the WRITE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      RB2_RW    <= RB_READ;
      RB2_A     <= '0;
      RB2_D     <= '0;
      done      <= 1'b0;
      frame_cnt <= '0;
`ifdef FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      RB2_RW <= RB_READ;
`ifdef FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!sen) state <= RECV;
        end
        RECV: begin
          if (sen) begin
            state <= IDLE;
`ifdef FRAME_CHECK_EN
            frame_err <= 1'b1;
`endif
          end else if (full) begin
            state  <= WRITE;
            RB2_RW <= RB_WRITE;
            RB2_A  <= word[FW-1:DATA_W];
            RB2_D  <= word[DATA_W-1:0];
          end
        end
        WRITE: begin
          frame_cnt <= frame_cnt + 1'b1;
          if (frame_cnt == CNT_W'(NUM_FRAMES - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!sen) begin
            state <= WAIT_HI;
`ifdef FRAME_CHECK_EN
            frame_err <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        WAIT_HI: begin
          if (sen) state <= IDLE;
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rb2_serial_writer.sv
// Directed bench for rb2_serial_writer: frame-level reference model checked every cycle,
// plus literal expectations on the documented scenarios.
module tb_rb2_serial_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sen;
  logic        sd;
  logic        RB2_RW;
  logic [2:0]  RB2_A;
  logic [17:0] RB2_D;
  logic [17:0] RB2_Q = '0;
  logic        done;
`ifdef FRAME_CHECK_EN
  logic        frame_err;
`endif

  rb2_serial_writer #(.ADDR_W(3), .DATA_W(18), .NUM_FRAMES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sen       (sen),
    .sd        (sd),
    .RB2_RW    (RB2_RW),
    .RB2_A     (RB2_A),
    .RB2_D     (RB2_D),
    .RB2_Q     (RB2_Q),
`ifdef FRAME_CHECK_EN
    .frame_err (frame_err),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int dut_writes  = 0;
  int dut_errs    = 0;
  bit checking    = 1'b0;

  // Frame-level model: counts consecutive sen-low bits since the link was last idle.
  logic        m_rw = 1'b1;
  logic [2:0]  m_a = '0;
  logic [17:0] m_d = '0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [20:0] m_bits = '0;
  int          m_run = 0;
  int          m_fcnt = 0;
  bit          m_wrote = 1'b0;
  bit          m_blocked = 1'b0;

  always @(posedge clk) begin
    m_err = 1'b0;
    if (rst) begin
      m_rw = 1'b1; m_a = '0; m_d = '0; m_done = 1'b0;
      m_bits = '0; m_run = 0; m_fcnt = 0; m_wrote = 1'b0; m_blocked = 1'b0;
    end else begin
      m_rw = 1'b1;
      if (m_done) begin
      end else if (m_wrote) begin
        m_wrote = 1'b0;
        m_fcnt++;
        if (m_fcnt == 8) m_done = 1'b1;
        else if (!sen) begin m_blocked = 1'b1; m_err = 1'b1; end
      end else if (m_blocked) begin
        if (sen) m_blocked = 1'b0;
      end else if (!sen) begin
        m_bits = {m_bits[19:0], sd};
        m_run++;
        if (m_run == 21) begin
          m_rw = 1'b0; m_a = m_bits[20:18]; m_d = m_bits[17:0];
          m_wrote = 1'b1; m_run = 0;
        end
      end else begin
        if (m_run > 0) m_err = 1'b1;
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (RB2_RW !== m_rw) begin miscompares++; $display("FAIL rw t=%0t got %b want %b", $time, RB2_RW, m_rw); end
      if (RB2_A !== m_a) begin miscompares++; $display("FAIL addr t=%0t got %0d want %0d", $time, RB2_A, m_a); end
      if (RB2_D !== m_d) begin miscompares++; $display("FAIL data t=%0t got %h want %h", $time, RB2_D, m_d); end
      if (done !== m_done) begin miscompares++; $display("FAIL done t=%0t got %b want %b", $time, done, m_done); end
`ifdef FRAME_CHECK_EN
      if (frame_err !== m_err) begin miscompares++; $display("FAIL frame_err t=%0t got %b want %b", $time, frame_err, m_err); end
      if (frame_err === 1'b1) dut_errs++;
`endif
      if (RB2_RW === 1'b0) dut_writes++;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic d);
    sen = s; sd = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(1'b1, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] a, input logic [17:0] d, input int extra);
    logic [20:0] f;
    f = {a, d};
    for (int i = 20; i >= 0; i--) step(1'b0, f[i]);
    repeat (extra) step(1'b0, 1'b1);
  endtask

  int w0;
  int e0;

  initial begin
    rst = 1'b1; sen = 1'b1; sd = 1'b0;
    step(1'b1, 1'b0);
    checking = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    lit("reset_rw", 32'(RB2_RW), 32'd1);
    lit("reset_done", 32'(done), 32'd0);
    lit("reset_addr", 32'(RB2_A), 32'd0);
    idle(2);

    // single frame, strobe visible the cycle after the 21st bit
    w0 = dut_writes;
    send_frame(3'b101, 18'h2A5C3, 0);
    @(negedge clk);
    lit("f1_rw", 32'(RB2_RW), 32'd0);
    lit("f1_addr", 32'(RB2_A), 32'd5);
    lit("f1_data", 32'(RB2_D), 32'h2A5C3);
    @(posedge clk); #1;
    idle(3);
    lit("f1_nwrites", 32'(dut_writes - w0), 32'd1);
    lit("f1_hold_addr", 32'(RB2_A), 32'd5);

    // eight frames to fill RB2, then further traffic must be ignored
    do_reset();
    w0 = dut_writes;
    for (int a = 0; a < 8; a++) begin
      send_frame(3'(a), 18'(a * 18'h01111), 0);
      idle(19);
    end
    lit("fill_nwrites", 32'(dut_writes - w0), 32'd8);
    lit("fill_done", 32'(done), 32'd1);
    lit("fill_last_data", 32'(RB2_D), 32'h07777);
    send_frame(3'd3, 18'h00555, 0);
    idle(5);
    lit("post_done_nwrites", 32'(dut_writes - w0), 32'd8);
    lit("post_done_done", 32'(done), 32'd1);

    // short frame dropped, then a valid one
    do_reset();
    w0 = dut_writes; e0 = dut_errs;
    repeat (10) step(1'b0, 1'b1);
    idle(2);
    send_frame(3'd2, 18'h3FFFF, 0);
    idle(3);
    lit("short_nwrites", 32'(dut_writes - w0), 32'd1);
    lit("short_addr", 32'(RB2_A), 32'd2);
    lit("short_data", 32'(RB2_D), 32'h3FFFF);
`ifdef FRAME_CHECK_EN
    lit("short_errs", 32'(dut_errs - e0), 32'd1);
`endif

    // overlong frame: 25 low cycles, only first 21 bits count
    do_reset();
    w0 = dut_writes; e0 = dut_errs;
    send_frame(3'd1, 18'h00001, 4);
    idle(3);
    lit("long_nwrites", 32'(dut_writes - w0), 32'd1);
    lit("long_addr", 32'(RB2_A), 32'd1);
    lit("long_data", 32'(RB2_D), 32'h00001);
`ifdef FRAME_CHECK_EN
    lit("long_errs", 32'(dut_errs - e0), 32'd1);
`endif

    // reset mid-frame at bit 12, then a full frame
    do_reset();
    w0 = dut_writes;
    for (int i = 0; i < 11; i++) step(1'b0, 1'(i % 2));
    rst = 1'b1; step(1'b0, 1'b1);
    rst = 1'b0;
    idle(2);
    send_frame(3'd7, 18'h12345, 0);
    idle(3);
    lit("rst_mid_nwrites", 32'(dut_writes - w0), 32'd1);
    lit("rst_mid_addr", 32'(RB2_A), 32'd7);
    lit("rst_mid_data", 32'(RB2_D), 32'h12345);
    lit("rst_mid_fcnt", 32'(dut.frame_cnt), 32'd1);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
